// File: rtl/nabp_image_writer_pkg.sv
// Shared constants and types for the image-writer stage.
package nabp_image_writer_pkg;

    localparam int kAccumulatedDataLength = 24;
    localparam int kImageDataLength       = 8;
    localparam int kImageAddressLength    = 16;
    localparam int kNoOfPartitions        = 4;
    localparam int kImageSize             = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/nabp_image_write_fifo.sv
// 2-deep first-word-fall-through FIFO. The head entry is a plain register,
// so dout is stable whenever the consumer holds off the pop.
module nabp_image_write_fifo #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Next head/tail/count; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (do_push) head_d = din;
            end
            2'd1: begin
                if (do_push && do_pop) head_d = din;
                else if (do_push)      tail_d = din;
            end
            default: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) tail_d = din;
                end
            end
        endcase
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/nabp_image_writer.sv
// Drains PE accumulators in partition order, scales/saturates them to
// pixel width and writes them to image RAM through a 2-entry FIFO.
module nabp_image_writer
    import nabp_image_writer_pkg::*;
#(
    parameter int NO_OF_PARTITIONS = kNoOfPartitions,
    parameter int ACC_WIDTH        = kAccumulatedDataLength,
    parameter int PIX_WIDTH        = kImageDataLength,
    parameter int SHIFT            = 8,
    parameter int IMAGE_SIZE       = kImageSize,
    parameter int ADDR_WIDTH       = kImageAddressLength
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  hs_kick,
    output logic                                  hs_done,
    input  logic [NO_OF_PARTITIONS-1:0]           pe_valid,
    input  logic [NO_OF_PARTITIONS*ACC_WIDTH-1:0] pe_val,
    output logic [NO_OF_PARTITIONS-1:0]           pe_ready,
    output logic                                  im_we,
    output logic [ADDR_WIDTH-1:0]                 im_addr,
    output logic [PIX_WIDTH-1:0]                  im_val,
    input  logic                                  im_wait
);

    localparam int P  = IMAGE_SIZE * IMAGE_SIZE / NO_OF_PARTITIONS;
    localparam int KW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = (NO_OF_PARTITIONS > 1) ? $clog2(NO_OF_PARTITIONS) : 1;

    // Arithmetic shift, then clamp negatives to 0 and overflows to all ones.
    function automatic logic [PIX_WIDTH-1:0] saturate(input logic [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] s;
        s = $signed(acc) >>> SHIFT;
        if (s[ACC_WIDTH-1])                    return '0;
        else if (|s[ACC_WIDTH-2:PIX_WIDTH])    return '1;
        else                                   return s[PIX_WIDTH-1:0];
    endfunction

    wr_state_e                 state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      hs_done_q, hs_done_d;

    logic [NO_OF_PARTITIONS-1:0][ACC_WIDTH-1:0] pe_val_a;
    logic [1:0]                fifo_count;
    logic                      accept, pop;
    logic [ADDR_WIDTH-1:0]     wr_addr;

    assign pe_val_a = pe_val;
    assign im_we    = (fifo_count != 2'd0);
    assign pop      = im_we && !im_wait;
    assign accept   = (state_q == ST_DRAIN) && pe_valid[idx_q] && (fifo_count < 2'd2);
    assign wr_addr  = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(P) + ADDR_WIDTH'(k_q);

    // Ready only to the partition being served, gated by registered occupancy.
    always_comb begin
        pe_ready = '0;
        if ((state_q == ST_DRAIN) && (fifo_count < 2'd2)) pe_ready[idx_q] = 1'b1;
    end

    // Drain sequencing; FLUSH leaves as the final pop happens so hs_done
    // lands in the very next cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        k_d       = k_q;
        hs_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_kick) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                    k_d     = '0;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    if (k_q == KW'(P - 1)) begin
                        k_d = '0;
                        if (idx_q == IW'(NO_OF_PARTITIONS - 1)) state_d = ST_FLUSH;
                        else                                     idx_d   = idx_q + 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
                    state_d   = ST_DONE;
                    hs_done_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            k_q       <= '0;
            hs_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            hs_done_q <= hs_done_d;
        end
    end

    assign hs_done = hs_done_q;

    nabp_image_write_fifo #(
        .WIDTH(ADDR_WIDTH + PIX_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (accept),
        .din   ({wr_addr, saturate(pe_val_a[idx_q])}),
        .pop   (pop),
        .dout  ({im_addr, im_val}),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_nabp_image_writer.sv
// Directed + randomized bench for nabp_image_writer (2 partitions, 4x4 image).
module tb_nabp_image_writer;

    localparam int N   = 2;
    localparam int ACC = 24;
    localparam int PIX = 8;
    localparam int SH  = 4;
    localparam int IS  = 4;
    localparam int AW  = 16;
    localparam int TOT = IS * IS;
    localparam int P   = TOT / N;

    logic             clk = 1'b0;
    logic             reset;
    logic             hs_kick;
    logic             hs_done;
    logic [N-1:0]     pe_valid;
    logic [N*ACC-1:0] pe_val;
    logic [N-1:0]     pe_ready;
    logic             im_we;
    logic [AW-1:0]    im_addr;
    logic [PIX-1:0]   im_val;
    logic             im_wait;

    int vectors = 0;
    int miscompares = 0;
    int vals[TOT];
    int cnt[N];

    always #5 clk = ~clk;

    nabp_image_writer #(
        .NO_OF_PARTITIONS(N), .ACC_WIDTH(ACC), .PIX_WIDTH(PIX),
        .SHIFT(SH), .IMAGE_SIZE(IS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .hs_kick(hs_kick), .hs_done(hs_done),
        .pe_valid(pe_valid), .pe_val(pe_val), .pe_ready(pe_ready),
        .im_we(im_we), .im_addr(im_addr), .im_val(im_val), .im_wait(im_wait)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel: sign-extend the 24-bit word, divide by 2^SH rounding
    // towards minus infinity, clamp into 0..255.
    function automatic int model_pix(input int raw);
        int sv, s;
        sv = raw & 32'h00FF_FFFF;
        if (sv >= (1 << 23)) sv = sv - (1 << 24);
        s = sv / (1 << SH);
        if ((sv < 0) && (sv % (1 << SH) != 0)) s = s - 1;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"},  hs_done, 0);
        chk({tag, "_ready"}, pe_ready, 0);
        chk({tag, "_we"},    im_we, 0);
        chk({tag, "_addr"},  im_addr, 0);
        chk({tag, "_val"},   im_val, 0);
    endtask

    // mode 0: always valid, no stall, stray kick mid-drain
    // mode 1: random valid and random stalls
    // mode 2: 5-cycle stall mid-stream
    // mode 3: PE 0 late, PE 1 valid from the start
    // mode 4: reset after 5 writes
    task automatic drain(input int mode);
        int  wr_idx, first_wr, last_wr, done_cyc, done_n, stall_acc, served;
        bit  pwait_we, was_reset;
        logic [AW-1:0]  pa;
        logic [PIX-1:0] pv;
        logic [N-1:0]   mask;
        wr_idx = 0; first_wr = -1; last_wr = -1; done_cyc = -1; done_n = 0;
        stall_acc = 0; pwait_we = 0; was_reset = 0; pa = '0; pv = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (mode == 4 && wr_idx == 5) begin
                reset = 1'b1; pe_valid = '0; hs_kick = 1'b0; im_wait = 1'b0;
                #1;
                check_reset_outputs("midreset");
                @(negedge clk);
                reset = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk); #1;
                    chk("post_reset_done", hs_done, 0);
                    chk("post_reset_we", im_we, 0);
                end
                was_reset = 1;
                break;
            end
            hs_kick = (cyc == 0) || (mode == 0 && cyc == 6);
            for (int i = 0; i < N; i++) begin
                pe_val[i*ACC +: ACC] = (cnt[i] < P) ? ACC'(vals[i*P + cnt[i]]) : ACC'($urandom);
                case (mode)
                    1:       pe_valid[i] = ($urandom_range(0, 3) != 0);
                    3:       pe_valid[i] = (i == 0) ? (cyc > 10) : 1'b1;
                    default: pe_valid[i] = 1'b1;
                endcase
            end
            case (mode)
                1:       im_wait = ($urandom_range(0, 2) == 0);
                2:       im_wait = (cyc >= 6 && cyc <= 10);
                default: im_wait = 1'b0;
            endcase
            #1;
            served = (cnt[0] < P) ? 0 : ((cnt[1] < P) ? 1 : -1);
            mask = (served >= 0) ? N'(1 << served) : '0;
            chk("ready_onehot", pe_ready & ~mask, 0);
            if (mode == 0 && cyc >= 1 && served >= 0) chk("ready_hi", pe_ready[served], 1);
            if (mode == 3 && cyc <= 10) chk("no_early_write", im_we, 0);
            if (mode == 2 && cyc >= 7 && cyc <= 10) chk("stall_ready", pe_ready, 0);
            if (pwait_we) begin
                chk("stall_we", im_we, 1);
                chk("stall_addr", im_addr, pa);
                chk("stall_val", im_val, pv);
            end
            pwait_we = im_we && im_wait;
            pa = im_addr;
            pv = im_val;
            if (im_we && !im_wait) begin
                if (wr_idx < TOT) begin
                    chk("wr_addr", im_addr, wr_idx);
                    chk("wr_val", im_val, model_pix(vals[wr_idx]));
                end else begin
                    chk("write_count", wr_idx + 1, TOT);
                end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr_idx++;
            end
            for (int i = 0; i < N; i++) begin
                if (pe_valid[i] && pe_ready[i]) begin
                    cnt[i]++;
                    if (mode == 2 && cyc >= 6 && cyc <= 10) stall_acc++;
                end
            end
            if (hs_done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("done_timing", cyc, last_wr + 1);
                    chk("done_writes", wr_idx, TOT);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        hs_kick = 1'b0;
        pe_valid = '0;
        im_wait = 1'b0;
        if (mode == 4) begin
            chk("reset_reached", was_reset, 1);
            chk("reset_no_done", done_n, 0);
        end else begin
            chk("done_pulses", done_n, 1);
            chk("total_writes", wr_idx, TOT);
            if (mode == 0) begin
                chk("first_write_cyc", first_wr, 2);
                chk("last_write_cyc", last_wr, 17);
            end
            if (mode == 2) chk("stall_accepts_le2", (stall_acc <= 2), 1);
        end
    endtask

    task automatic load_ramp();
        for (int j = 0; j < TOT; j++) vals[j] = j * 16;
    endtask

    task automatic load_random();
        for (int j = 0; j < TOT; j++)
            vals[j] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 12287)) - 4096
                                                  : int'($urandom_range(0, 32'h00FF_FFFF));
    endtask

    initial begin
        reset = 1'b1; hs_kick = 1'b0; pe_valid = '0; pe_val = '0; im_wait = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        load_ramp();
        drain(0);

        load_random();
        vals[0] = -32;
        vals[1] = 32'h0000_1000;
        vals[2] = 32'h0000_0FF0;
        vals[3] = 32'h0000_007F;
        drain(1);

        for (int r = 0; r < 3; r++) begin
            load_random();
            drain(1);
        end

        load_random();
        drain(2);

        load_random();
        drain(3);

        load_random();
        drain(4);

        load_ramp();
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
